// File: rtl/student_fir_sample_feeder_if.sv
// Stream and FIR-side handshake bundle for the FIR sample feeder.
// The slave modport is the feeder's view; the master modport is the view of whatever drives it.
interface student_fir_sample_feeder_if #(
   parameter int unsigned DATA_SIZE = 16
) ();
   logic                 s_valid_i;
   logic                 s_ready_o;
   logic [DATA_SIZE-1:0] s_data_i;
   logic                 fir_valid_strobe_o;
   logic [DATA_SIZE-1:0] fir_sample_o;
   logic                 fir_done_i;

   modport slave (
      input  s_valid_i, s_data_i, fir_done_i,
      output s_ready_o, fir_valid_strobe_o, fir_sample_o
   );

   modport master (
      output s_valid_i, s_data_i, fir_done_i,
      input  s_ready_o, fir_valid_strobe_o, fir_sample_o
   );
endinterface

// File: rtl/student_fir_sample_feeder.sv
// Buffers upstream samples in a FIFO and hands them to the FIR one at a time,
// waiting for the FIR's completion strobe (with an optional watchdog) before the next issue.
module student_fir_sample_feeder #(
   parameter int unsigned DATA_SIZE     = 16,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned TIMEOUT_WIDTH = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   student_fir_sample_feeder_if.slave   bus,
   input  logic                         enable_i,
   input  logic [TIMEOUT_WIDTH-1:0]     timeout_cycles_i,
   input  logic                         err_clr_i,
   output logic                         busy_o,
   output logic [$clog2(FIFO_DEPTH):0]  fill_level_o,
   output logic                         timeout_err_o,
   output logic [31:0]                  issued_cnt_o
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, WAIT} state_e;

   state_e                   state_q, state_d;
   logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
   logic                     issue, timeout_hit;

   logic [DATA_SIZE-1:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]         fill_q;
   logic                     full, push;

   logic                     strobe_q;
   logic [DATA_SIZE-1:0]     sample_q;
   logic [31:0]              cnt_q;
   logic                     err_q;

   // Ready is held low while reset is asserted and otherwise tracks "not full".
   assign full          = (fill_q == CNT_W'(FIFO_DEPTH));
   assign bus.s_ready_o = rst_ni & ~full;
   assign push          = bus.s_valid_i & bus.s_ready_o;

   // FSM state and watchdog counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   end

   // Next state; completion beats the watchdog when both occur at the same edge.
   always_comb begin
      state_d     = state_q;
      wd_d        = wd_q;
      issue       = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i && (fill_q != '0)) begin
               issue   = 1'b1;
               wd_d    = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.fir_done_i) begin
               state_d = IDLE;
            end else if ((timeout_cycles_i != '0) &&
                         (wd_q == timeout_cycles_i - TIMEOUT_WIDTH'(1))) begin
               timeout_hit = 1'b1;
               state_d     = IDLE;
            end else begin
               wd_d = wd_q + TIMEOUT_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO storage; emptiness is defined by the pointers, so no reset is needed here.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.s_data_i;
      end
   end

   // FIFO pointers/level and registered FIR-side outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         strobe_q <= 1'b0;
         sample_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (issue) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            sample_q <= mem_q[rd_ptr_q];
            cnt_q    <= cnt_q + 32'd1;
         end
         case ({push, issue})
            2'b10:   fill_q <= fill_q + CNT_W'(1);
            2'b01:   fill_q <= fill_q - CNT_W'(1);
            default: fill_q <= fill_q;
         endcase
         strobe_q <= issue;
         if (timeout_hit) begin
            err_q <= 1'b1;
         end else if (err_clr_i) begin
            err_q <= 1'b0;
         end
      end
   end

   assign bus.fir_valid_strobe_o = strobe_q;
   assign bus.fir_sample_o       = sample_q;
   assign busy_o                 = (state_q == WAIT);
   assign fill_level_o           = fill_q;
   assign timeout_err_o          = err_q;
   assign issued_cnt_o           = cnt_q;
endmodule

// File: tb/tb_student_fir_sample_feeder.sv
// Self-checking bench for student_fir_sample_feeder: directed scenarios plus random traffic,
// all checked every cycle against a queue-based transaction model.
module tb_student_fir_sample_feeder;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TW    = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [TW-1:0] tmo;
   logic          err_clr;
   logic          busy;
   logic [3:0]    fill;
   logic          err;
   logic [31:0]   cnt;

   student_fir_sample_feeder_if #(.DATA_SIZE(DW)) bus ();

   student_fir_sample_feeder #(
      .DATA_SIZE(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_WIDTH(TW)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .bus              (bus),
      .enable_i         (enable),
      .timeout_cycles_i (tmo),
      .err_clr_i        (err_clr),
      .busy_o           (busy),
      .fill_level_o     (fill),
      .timeout_err_o    (err),
      .issued_cnt_o     (cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Transaction-level reference: a sample queue, a busy flag and edges elapsed since issue.
   logic [DW-1:0] mq[$];
   bit            m_busy;
   int            m_elapsed;
   bit            m_strobe;
   logic [DW-1:0] m_sample;
   int unsigned   m_cnt;
   bit            m_err;

   task automatic model_reset();
      mq.delete();
      m_busy    = 1'b0;
      m_elapsed = 0;
      m_strobe  = 1'b0;
      m_sample  = '0;
      m_cnt     = 0;
      m_err     = 1'b0;
   endtask

   task automatic model_edge();
      bit can_push = (mq.size() != int'(DEPTH));
      bit set_err  = 1'b0;
      m_strobe = 1'b0;
      if (!m_busy) begin
         if (enable && mq.size() > 0) begin
            m_sample  = mq.pop_front();
            m_strobe  = 1'b1;
            m_cnt     = m_cnt + 1;
            m_busy    = 1'b1;
            m_elapsed = 0;
         end
      end else if (bus.fir_done_i) begin
         m_busy = 1'b0;
      end else if (tmo != '0 && m_elapsed + 1 == int'(tmo)) begin
         m_busy  = 1'b0;
         set_err = 1'b1;
      end else begin
         m_elapsed++;
      end
      if (set_err) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (bus.s_valid_i && can_push) mq.push_back(bus.s_data_i);
   endtask

   task automatic compare_all();
      check("strobe", 64'(bus.fir_valid_strobe_o), 64'(m_strobe));
      check("sample", 64'(bus.fir_sample_o), 64'(m_sample));
      check("busy",   64'(busy), 64'(m_busy));
      check("fill",   64'(fill), 64'(mq.size()));
      check("ready",  64'(bus.s_ready_o), 64'(mq.size() != int'(DEPTH)));
      check("err",    64'(err), 64'(m_err));
      check("count",  64'(cnt), 64'(m_cnt));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_strobe"}, 64'(bus.fir_valid_strobe_o), 64'd0);
      check({tag, "_sample"}, 64'(bus.fir_sample_o), 64'd0);
      check({tag, "_busy"},   64'(busy), 64'd0);
      check({tag, "_fill"},   64'(fill), 64'd0);
      check({tag, "_ready"},  64'(bus.s_ready_o), 64'd0);
      check({tag, "_err"},    64'(err), 64'd0);
      check({tag, "_count"},  64'(cnt), 64'd0);
   endtask

   logic [DW-1:0] t2_words [3];

   initial begin
      t2_words[0] = 16'hA001;
      t2_words[1] = 16'hA002;
      t2_words[2] = 16'hA003;
      rst_n = 1'b1;
      enable = 1'b0; tmo = '0; err_clr = 1'b0;
      bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.fir_done_i = 1'b0;
      #1 rst_n = 1'b0;
      #2 check_all_zero("rst");
      model_reset();
      #19 rst_n = 1'b1;
      #1 check("rst_release_ready", 64'(bus.s_ready_o), 64'd1);

      // 1: single sample, latency of one edge from accept to strobe
      enable = 1'b1; bus.s_valid_i = 1'b1; bus.s_data_i = 16'h1234;
      step();
      check("t1_no_strobe_yet", 64'(bus.fir_valid_strobe_o), 64'd0);
      bus.s_valid_i = 1'b0;
      step();
      check("t1_strobe", 64'(bus.fir_valid_strobe_o), 64'd1);
      check("t1_sample", 64'(bus.fir_sample_o), 64'h1234);
      check("t1_busy",   64'(busy), 64'd1);
      check("t1_count",  64'(cnt), 64'd1);
      check("t1_fill",   64'(fill), 64'd0);
      step();
      check("t1_strobe_one_cycle", 64'(bus.fir_valid_strobe_o), 64'd0);
      bus.fir_done_i = 1'b1; step(); bus.fir_done_i = 1'b0;

      // 2: three samples, done pulsed 5 cycles after each strobe
      enable = 1'b0; bus.s_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.s_data_i = t2_words[i];
         step();
      end
      bus.s_valid_i = 1'b0; enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         int w = 0;
         step();
         while (!bus.fir_valid_strobe_o && w < 20) begin step(); w++; end
         check("t2_strobe", 64'(bus.fir_valid_strobe_o), 64'd1);
         check("t2_sample", 64'(bus.fir_sample_o), 64'(t2_words[i]));
         repeat (4) step();
         bus.fir_done_i = 1'b1; step(); bus.fir_done_i = 1'b0;
      end
      check("t2_count", 64'(cnt), 64'd4);

      // 3: fill to full with issuing disabled, then release
      enable = 1'b0; bus.s_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.s_data_i = DW'(16'hB000 + i);
         step();
      end
      check("t3_full_level", 64'(fill), 64'd8);
      check("t3_full_ready", 64'(bus.s_ready_o), 64'd0);
      bus.s_data_i = 16'hB008;
      step(); step();
      check("t3_no_push_when_full", 64'(fill), 64'd8);
      enable = 1'b1;
      step();
      check("t3_pop_sample", 64'(bus.fir_sample_o), 64'hB000);
      check("t3_ready_after_pop", 64'(bus.s_ready_o), 64'd1);
      step();
      check("t3_ninth_push", 64'(fill), 64'd8);
      bus.s_valid_i = 1'b0;

      // 4: watchdog expiry, clear, then done exactly at the limit
      bus.fir_done_i = 1'b1; step(); bus.fir_done_i = 1'b0;
      tmo = TW'(4);
      step();
      check("t4_issue", 64'(bus.fir_sample_o), 64'hB001);
      repeat (3) step();
      check("t4_no_err_early", 64'(err), 64'd0);
      check("t4_busy_early",   64'(busy), 64'd1);
      step();
      check("t4_err_set",  64'(err), 64'd1);
      check("t4_not_busy", 64'(busy), 64'd0);
      step();
      check("t4_next_strobe", 64'(bus.fir_valid_strobe_o), 64'd1);
      check("t4_next_sample", 64'(bus.fir_sample_o), 64'hB002);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("t4_err_cleared", 64'(err), 64'd0);
      step(); step();
      bus.fir_done_i = 1'b1; step(); bus.fir_done_i = 1'b0;
      check("t4_done_wins", 64'(err), 64'd0);
      check("t4_done_idle", 64'(busy), 64'd0);
      tmo = '0;

      // 5: asynchronous reset while waiting with entries queued
      step();
      enable = 1'b0;
      check("t5_busy_before_rst", 64'(busy), 64'd1);
      check("t5_queued", 64'(fill >= 4'd3), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("t5_rst");
      model_reset();
      #2 rst_n = 1'b1;
      bus.fir_done_i = 1'b1; step(); bus.fir_done_i = 1'b0;
      check("t5_no_strobe_on_done", 64'(bus.fir_valid_strobe_o), 64'd0);

      // 6: enable dropped right after an issue
      bus.s_valid_i = 1'b1;
      bus.s_data_i = 16'hC001; step();
      bus.s_data_i = 16'hC002; step();
      bus.s_valid_i = 1'b0;
      enable = 1'b1; step();
      check("t6_issue", 64'(bus.fir_sample_o), 64'hC001);
      enable = 1'b0; step();
      bus.fir_done_i = 1'b1; step(); bus.fir_done_i = 1'b0;
      repeat (3) step();
      check("t6_held_idle", 64'(busy), 64'd0);
      check("t6_held_fill", 64'(fill), 64'd1);
      enable = 1'b1; step();
      check("t6_resume_strobe", 64'(bus.fir_valid_strobe_o), 64'd1);
      check("t6_resume_sample", 64'(bus.fir_sample_o), 64'hC002);

      // Random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         bus.s_valid_i  = ($urandom_range(0, 99) < 55);
         bus.s_data_i   = DW'($urandom);
         enable         = ($urandom_range(0, 99) < 85);
         bus.fir_done_i = m_busy ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 5);
         err_clr        = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 99) < 3) tmo = TW'($urandom_range(0, 6));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/student_fir_sample_feeder.md
Name: student_fir_sample_feeder

Overview:
Producer-side companion to the parallel FIR. It buffers incoming audio samples from an upstream valid/ready stream in a small FIFO. It issues them one at a time to the FIR's sample_in/valid_strobe_in pair, and it issues the next sample only after the FIR's valid_strobe_out reports that the current computation has finished. A watchdog flags a FIR that never completes. Status and counters are exported for a register block.

Parameters:
DATA_SIZE, 16, sample width (matches FIR DATA_SIZE)
FIFO_DEPTH, 8, FIFO entries; power of 2, >= 2
TIMEOUT_WIDTH, 16, width of the watchdog limit and counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
s_valid_i  in  1  upstream sample valid
s_ready_o  out  1  upstream ready; equals !full
s_data_i  in  DATA_SIZE  upstream sample
enable_i  in  1  permits issuing new samples
fir_valid_strobe_o  out  1  one-cycle issue pulse to FIR valid_strobe_in
fir_sample_o  out  DATA_SIZE  sample to FIR sample_in; registered, holds last issued value
fir_done_i  in  1  FIR valid_strobe_out (computation finished)
timeout_cycles_i  in  TIMEOUT_WIDTH  watchdog limit; 0 disables the watchdog
err_clr_i  in  1  clears timeout_err_o
busy_o  out  1  high while in WAIT
fill_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
timeout_err_o  out  1  sticky watchdog error
issued_cnt_o  out  32  count of samples issued; wraps at 2^32

Behaviour:
- Reset, asynchronous, active-low, overrides everything mid-operation:
  - state IDLE
  - FIFO emptied
  - all outputs 0; s_ready_o=1 once out of reset
  - watchdog counter 0
- FIFO:
  - Push when s_valid_i && s_ready_o.
  - s_ready_o = (fill_level_o != FIFO_DEPTH). There is no push-through when full, even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is preserved.
- FSM states: IDLE, WAIT.
- IDLE:
  - At an edge where enable_i=1 and fill_level_o>0:
    - pop the head into fir_sample_o
    - set fir_valid_strobe_o=1 for exactly one cycle
    - increment issued_cnt_o
    - clear the watchdog counter
    - go to WAIT
  - fir_done_i is ignored in IDLE.
- WAIT (busy_o=1):
  - At an edge with fir_done_i=1: go to IDLE.
  - At an edge with fir_done_i=0, timeout_cycles_i!=0 and counter==timeout_cycles_i-1: set timeout_err_o and go to IDLE. The sample is not reissued.
  - Otherwise the counter increments at each edge.
  - If done and the limit coincide at the same edge, done wins and no error is raised.
  - With timeout_cycles_i=0 the block waits indefinitely.
- enable_i deasserted in WAIT: the current transaction completes normally; no new issue follows until enable_i returns high.
- Latency: a sample accepted at edge k into an empty FIFO in IDLE with enable_i=1 produces fir_valid_strobe_o high between edges k+1 and k+2.
- Minimum issue spacing:
  - WAIT is entered at the issue edge; a done sampled at the very next edge is accepted.
  - Back-to-back issues are therefore separated by at least one low cycle on the strobe. This is required by the FIR's rising-edge detector.
- fir_sample_o is stable from the issue edge until the next issue.
- timeout_err_o:
  - set has priority over err_clr_i at the same edge
  - otherwise err_clr_i clears it
  - it does not block issuing

Test Plan:
1. Reset, then push 0x1234 at edge k with enable_i=1 -> fir_valid_strobe_o=1 only in cycle k+1..k+2, fir_sample_o=0x1234, busy_o=1, issued_cnt_o=1, fill_level_o 1->0.
2. Push 0xA001, 0xA002, 0xA003; pulse fir_done_i 5 cycles after each strobe -> three strobes in order with matching fir_sample_o. No strobe while busy; each new strobe appears the edge after done is sampled; issued_cnt_o=3.
3. Hold fir_done_i=0 and s_valid_i=1 with enable_i=0 -> 8 pushes accepted, then s_ready_o=0 and fill_level_o=8. Raise enable_i -> first pop, s_ready_o=1 next cycle; the 9th word is accepted in order.
4. timeout_cycles_i=4, issue at edge k, no done -> timeout_err_o=1 and busy_o=0 after edge k+4, next queued sample strobed at k+5. Pulse err_clr_i -> error clears. Repeat with done at exactly edge k+4 -> no error.
5. Assert rst_ni low while in WAIT with 3 entries queued -> all outputs 0 and fill_level_o=0 immediately (asynchronously). After release, a fir_done_i pulse causes no strobe.
6. enable_i dropped one cycle after an issue -> done returns to IDLE; no further strobe until enable_i=1 again. Strobe follows at the first edge with enable_i=1.
